// File: rtl/psum_acc_pkg.sv
// -----------------------------------------------------------------------------
// psum_acc_pkg
// Shared definitions for the partial-sum accumulator and the scale/requantize
// stage that consumes its output.
//   DN  : lanes per beat (shared with the scale stage)
//   IW  : signed partial-sum width per lane
//   BW  : signed bias width per lane
//   DW  : signed output lane width (shared with the scale stage m_data1 lanes)
//   CW  : beat/group counter width
//   AW  : accumulator width; wide enough that 2^CW-1 beats of IW-bit values
//         plus a BW-bit bias can never wrap
// Also holds the accumulator FSM state type and the signed saturator.
// -----------------------------------------------------------------------------
package psum_acc_pkg;

  localparam int DN = 6;
  localparam int IW = 16;
  localparam int BW = 16;
  localparam int DW = 22;
  localparam int CW = 10;
  localparam int AW = IW + CW + 1;

  // Clamp limits of a DW-bit signed value, expressed at accumulator width.
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  typedef struct packed {
    logic          ovf;
    logic [DW-1:0] val;
  } sat_t;

  // Saturate an accumulator-width signed value to DW bits and flag the clamp.
  function automatic sat_t sat_DW(input logic signed [AW-1:0] v);
    sat_t r;
    if (v > SAT_MAX) begin
      r.val = SAT_MAX[DW-1:0];
      r.ovf = 1'b1;
    end else if (v < SAT_MIN) begin
      r.val = SAT_MIN[DW-1:0];
      r.ovf = 1'b1;
    end else begin
      r.val = v[DW-1:0];
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_lane.sv
// -----------------------------------------------------------------------------
// psum_lane
// One lane of the partial-sum accumulator: AW-bit signed accumulator with bias
// preload, plus the DW-bit saturator applied to (acc + current beat).
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : job start; capture bias and preload the accumulator with it
//   add        : a beat transfers this cycle
//   last       : the transferring beat closes the group; re-arm with bias
//   bias       : signed bias for this lane (captured on load)
//   in_data    : signed partial sum for this lane
//   sat_val    : saturated (acc + in_data), valid when add && last
//   sat_ovf    : sat_val was clamped
// -----------------------------------------------------------------------------
module psum_lane
  import psum_acc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          add,
  input  logic          last,
  input  logic [BW-1:0] bias,
  input  logic [IW-1:0] in_data,
  output logic [DW-1:0] sat_val,
  output logic          sat_ovf
);

  logic signed [AW-1:0] acc_r;
  logic        [BW-1:0] bias_r;
  logic signed [AW-1:0] in_ext_s;
  logic signed [AW-1:0] bias_in_ext_s;
  logic signed [AW-1:0] bias_hold_ext_s;
  logic signed [AW-1:0] sum_s;
  sat_t                 sat_s;

  // Sign extension of operands, running sum including the current beat, and saturation.
  always_comb begin
    in_ext_s        = {{(AW-IW){in_data[IW-1]}}, in_data};
    bias_in_ext_s   = {{(AW-BW){bias[BW-1]}}, bias};
    bias_hold_ext_s = {{(AW-BW){bias_r[BW-1]}}, bias_r};
    sum_s           = acc_r + in_ext_s;
    sat_s           = sat_DW(sum_s);
  end

  assign sat_val = sat_s.val;
  assign sat_ovf = sat_s.ovf;

  // Accumulator and held bias; a closing beat re-arms the lane for the next group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r  <= {AW{1'b0}};
      bias_r <= {BW{1'b0}};
    end else if (load) begin
      bias_r <= bias;
      acc_r  <= bias_in_ext_s;
    end else if (add) begin
      if (last) begin
        acc_r <= bias_hold_ext_s;
      end else begin
        acc_r <= sum_s;
      end
    end
  end

endmodule

// File: rtl/psum_acc.sv
// -----------------------------------------------------------------------------
// psum_acc
// Partial-sum accumulator feeding the per-channel scale/requantize stage.
// Accumulates acc_len beats of DN signed lanes on top of a per-lane bias,
// saturates each lane to DW bits and emits one m_valid1 pulse per group, for
// n_groups groups back-to-back without bubbles.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : one-cycle job start, only honoured in IDLE
//   acc_len     : beats per group (0 behaves as 1), latched on start
//   n_groups    : groups per job (0 behaves as 1), latched on start
//   bias        : DN x BW signed per-lane bias, latched on start
//   in_data     : DN x IW signed partial sums, lane i at [i*IW +: IW]
//   in_valid    : in_data valid
//   in_ready    : beat accepted when in_valid && in_ready
//   m_data1     : DN x DW saturated sums, held between pulses
//   m_valid1    : one-cycle pulse per completed group
//   busy        : job in progress
//   done        : pulse with the final group's m_valid1
//   err_ovf     : sticky lane-saturation flag, cleared on start
// -----------------------------------------------------------------------------
module psum_acc #(
  parameter int DN = psum_acc_pkg::DN,
  parameter int IW = psum_acc_pkg::IW,
  parameter int BW = psum_acc_pkg::BW,
  parameter int DW = psum_acc_pkg::DW,
  parameter int CW = psum_acc_pkg::CW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    acc_len,
  input  logic [CW-1:0]    n_groups,
  input  logic [DN*BW-1:0] bias,
  input  logic [DN*IW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DN*DW-1:0] m_data1,
  output logic             m_valid1,
  output logic             busy,
  output logic             done,
  output logic             err_ovf
);

  import psum_acc_pkg::*;

  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nx_s;
  logic [CW-1:0]    len_r;
  logic [CW-1:0]    ngrp_r;
  logic [CW-1:0]    beat_cnt_r;
  logic [CW-1:0]    grp_cnt_r;
  logic [DN*DW-1:0] m_data1_r;
  logic             m_valid1_r;
  logic             done_r;
  logic             err_ovf_r;

  logic             acc_s;
  logic             load_s;
  logic             xfer_s;
  logic             last_beat_s;
  logic             last_grp_s;
  logic [DN*DW-1:0] sat_vec_s;
  logic [DN-1:0]    ovf_vec_s;

  // Handshake and group-boundary decode from the registered state and counters.
  always_comb begin
    acc_s       = (state_r == ACC);
    load_s      = (state_r == IDLE) && start;
    xfer_s      = acc_s && in_valid;
    last_beat_s = xfer_s && (beat_cnt_r == (len_r - ONE_C));
    last_grp_s  = (grp_cnt_r == (ngrp_r - ONE_C));
  end

  for (genvar i = 0; i < DN; i++) begin : g_lane
    psum_lane u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load_s),
      .add     (xfer_s),
      .last    (last_beat_s),
      .bias    (bias[i*BW +: BW]),
      .in_data (in_data[i*IW +: IW]),
      .sat_val (sat_vec_s[i*DW +: DW]),
      .sat_ovf (ovf_vec_s[i])
    );
  end

  // Next-state logic: leave ACC only when the closing beat of the final group transfers.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = ACC;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACC: begin
        if (last_beat_s && last_grp_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = ACC;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Job parameters, beat/group counters, output register and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r      <= ZERO_C;
      ngrp_r     <= ZERO_C;
      beat_cnt_r <= ZERO_C;
      grp_cnt_r  <= ZERO_C;
      m_data1_r  <= {(DN*DW){1'b0}};
      m_valid1_r <= 1'b0;
      done_r     <= 1'b0;
      err_ovf_r  <= 1'b0;
    end else begin
      m_valid1_r <= 1'b0;
      done_r     <= 1'b0;
      if (load_s) begin
        // A zero length or group count would never terminate; treat it as one.
        len_r      <= (acc_len == ZERO_C) ? ONE_C : acc_len;
        ngrp_r     <= (n_groups == ZERO_C) ? ONE_C : n_groups;
        beat_cnt_r <= ZERO_C;
        grp_cnt_r  <= ZERO_C;
        err_ovf_r  <= 1'b0;
      end else if (last_beat_s) begin
        m_data1_r  <= sat_vec_s;
        m_valid1_r <= 1'b1;
        beat_cnt_r <= ZERO_C;
        grp_cnt_r  <= grp_cnt_r + ONE_C;
        done_r     <= last_grp_s;
        err_ovf_r  <= err_ovf_r | (|ovf_vec_s);
      end else if (xfer_s) begin
        beat_cnt_r <= beat_cnt_r + ONE_C;
      end
    end
  end

  // busy/in_ready come straight from the state register, so they drop in the
  // same cycle as the final m_valid1/done pulse.
  assign in_ready = acc_s;
  assign busy     = acc_s;
  assign m_data1  = m_data1_r;
  assign m_valid1 = m_valid1_r;
  assign done     = done_r;
  assign err_ovf  = err_ovf_r;

endmodule

// File: doc/psum_acc.md
# psum_acc

Partial-sum accumulator that sits directly upstream of the per-channel scale/requantize stage. Each cycle it accepts one beat of DN signed partial sums from the PE array. It adds each lane to a bias-preloaded accumulator over a programmable number of beats. When a group completes, it saturates each lane to DW bits and presents the result on m_data1/m_valid1 for the scale stage. It can run several output groups back-to-back without bubbles.

## Interface
Parameters:
- DN, 6, lanes per beat (matches scale stage)
- IW, 16, signed partial-sum width per lane
- BW, 16, signed bias width per lane
- DW, 22, signed output width per lane (matches scale stage m_data1 lane width)
- CW, 10, width of beat/group counters
- AW, IW+CW+1, internal accumulator width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; starts a job; sampled only in IDLE
- acc_len  in  CW  beats per group, latched on start; 0 is treated as 1
- n_groups  in  CW  groups per job, latched on start; 0 is treated as 1
- bias  in  DN*BW  per-lane signed bias, latched on start, reused for every group
- in_data  in  DN*IW  lane i at [i*IW +: IW], signed
- in_valid  in  1  in_data valid
- in_ready  out  1  accumulator accepts a beat; a beat transfers when in_valid && in_ready
- m_data1  out  DN*DW  saturated sums, lane i at [i*DW +: DW]
- m_valid1  out  1  one-cycle pulse per completed group
- busy  out  1  high when not IDLE
- done  out  1  one-cycle pulse coincident with the last group's m_valid1
- err_ovf  out  1  sticky; set when any lane saturates; cleared on start

## Operation
- States: IDLE and ACC.
- IDLE: in_ready=0. On start:
  - acc[i] <= sign-extend(bias[i]) to AW bits.
  - beat_cnt <= 0, grp_cnt <= 0.
  - Latch len and ngrp.
  - Clear err_ovf.
  - Go to ACC.
- ACC: in_ready=1. On each transfer, acc[i] <= acc[i] + sign-extend(in_data[i]), and beat_cnt increments.
- Last beat (transfer with beat_cnt==len-1):
  - m_data1[i] <= sat_DW(acc[i] + in_data[i]).
  - m_valid1 <= 1.
  - acc[i] <= sign-extend(bias[i]); beat_cnt <= 0; grp_cnt increments.
  - If grp_cnt==ngrp-1: done <= 1 and return to IDLE. Otherwise stay in ACC with no bubble.
- Saturation: a value above 2^(DW-1)-1 clamps to 2^(DW-1)-1, and a value below -2^(DW-1) clamps to -2^(DW-1). Either clamp sets err_ovf. AW guarantees no internal wrap for len up to 2^CW-1.
- start while busy is ignored. in_valid in IDLE is ignored (no transfer).
- m_data1 holds its last value between pulses.

## Timing
- Reset values:
  - state IDLE.
  - m_data1=0, m_valid1=0, done=0, err_ovf=0, busy=0, in_ready=0.
  - All accumulators and counters 0.
- start at cycle t gives busy=1 and in_ready=1 from t+1.
- Latency: m_valid1 rises on the cycle after the last beat of a group transfers.
- Throughput: one beat per cycle. The first beat of group g+1 may transfer in the same cycle that group g's m_valid1 is high.
- After the final group: busy and in_ready drop in the same cycle done and m_valid1 pulse. A new start is accepted in that same cycle, since the state is IDLE.
- Gaps in in_valid stall accumulation only. There is no timeout.
- rst_n low mid-job aborts it on the next edge: no m_valid1, no done, partial sums discarded.

## Structure
- Shared package holds:
  - DN, IW, DW and the lane width constants common with the scale stage.
  - The state enum {IDLE, ACC}.
  - The signed saturation function sat_DW.
- One sub-module, psum_lane: one lane's AW-bit accumulator, bias preload, and DW saturator with overflow flag. Generated DN times.
- The top level owns the FSM, counters, latching, and the output register.

## Test plan
- Single group: bias=0, acc_len=4, n_groups=1, all lanes fed 100,200,300,400. Expect m_valid1 once with every lane =1000, done in the same cycle, then busy=0.
- Bias and sign: bias lane0=-5, lane1=7; acc_len=3; lane0 fed -1,-1,-1 and lane1 fed 2,2,2. Expect lane0=-8 and lane1=13.
- Back-to-back groups: acc_len=2, n_groups=3, continuous in_valid. Expect three m_valid1 pulses spaced exactly 2 cycles apart, bias re-applied each group, and done on the third pulse.
- Saturation: acc_len=100, bias 0, lane0 fed +32767 and lane1 fed -32768 each beat. Expect lane0=2097151, lane1=-2097152, and err_ovf=1 until the next start clears it.
- Stalls and edge cases:
  - acc_len=0 and n_groups=0 behave as 1.
  - Random in_valid gaps give sums equal to a golden model.
  - start asserted while busy is ignored.
- Reset mid-job: assert rst_n=0 after 2 of 4 beats. Expect all outputs 0 next cycle and no m_valid1. A following job produces correct sums with no leftover partial sums.
